// File: rtl/ttt_win_scan_pkg.sv
// ============================================================================
//  Module   : ttt_pkg
//  Purpose  : Shared constants for ttt_win_scan: winner codes, scan limits,
//             FSM state codes and the canonical win-line / full-board masks.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ttt_pkg;

    localparam int CELLS     = 9;
    localparam int LAST_LINE = 7;
    localparam int FULL_SEL  = 8;

    localparam logic [3:0] NO_LINE = 4'hF;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    // Selects 0..7 are the win lines (rows, columns, diagonals); 8 is the full board.
    function automatic logic [8:0] canon_mask(input logic [3:0] sel);
        logic [8:0] m;
        m = 9'h000;
        case (sel)
            4'd0:    m = 9'h007;
            4'd1:    m = 9'h038;
            4'd2:    m = 9'h1C0;
            4'd3:    m = 9'h049;
            4'd4:    m = 9'h092;
            4'd5:    m = 9'h124;
            4'd6:    m = 9'h111;
            4'd7:    m = 9'h054;
            4'd8:    m = 9'h1FF;
            default: m = 9'h000;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_win_scan_if.sv
// ============================================================================
//  Module   : ttt_win_scan_if
//  Purpose  : Select/mask link between the win scanner and the pattern mux.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ttt_win_scan_if #(
    parameter int SEL_W = 4,
    parameter int CELLS = 9
);
    logic [SEL_W-1:0] mux_sel;
    logic [CELLS-1:0] mux_out;

    modport master (output mux_sel, input  mux_out);
    modport slave  (input  mux_sel, output mux_out);
endinterface

`default_nettype wire

// File: rtl/ttt_win_scan_mask_match.sv
// ============================================================================
//  Module   : ttt_mask_match
//  Purpose  : Combinational subset test of a mux mask against the X, O and
//             combined boards.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ttt_mask_match #(
    parameter int CELLS = 9
) (
    input  logic [CELLS-1:0] mask,
    input  logic [CELLS-1:0] bx,
    input  logic [CELLS-1:0] bo,
    output logic             xm,
    output logic             om,
    output logic             full
);

    assign xm   = ((bx & mask) == mask);
    assign om   = ((bo & mask) == mask);
    assign full = (((bx | bo) & mask) == mask);

endmodule

`default_nettype wire

// File: rtl/ttt_win_scan.sv
// ============================================================================
//  Module   : ttt_win_scan
//  Purpose  : Steps the pattern-mux select through the 8 win lines and the
//             full-board mask, reporting X win, O win, draw or no result.
//             TTT_WIN_SCAN_EARLY_EXIT_EN: report on the first line hit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ttt_win_scan #(
    parameter int CELLS     = 9,
    parameter int SEL_W     = 4,
    parameter int LAST_LINE = 7,
    parameter int FULL_SEL  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CELLS-1:0] board_x,
    input  logic [CELLS-1:0] board_o,
    ttt_win_scan_if.master   mux,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic [3:0]       win_line
);

    import ttt_pkg::*;

    logic [0:0]       state_q,  state_d;
    logic [SEL_W-1:0] sel_q,    sel_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [1:0]       winner_q, winner_d;
    logic [3:0]       line_q,   line_d;
    logic [CELLS-1:0] bx_q,     bx_d;
    logic [CELLS-1:0] bo_q,     bo_d;
    logic             found_q,  found_d;
    logic [1:0]       who_q,    who_d;
    logic [3:0]       idx_q,    idx_d;

    logic             w_xm, w_om, w_full;
    logic             w_is_line, w_is_full, w_hit;
    logic [1:0]       w_hit_who;
    logic             w_report;
    logic [1:0]       w_rep_winner;
    logic [3:0]       w_rep_line;

    ttt_mask_match #(.CELLS(CELLS)) u_match (
        .mask (mux.mux_out),
        .bx   (bx_q),
        .bo   (bo_q),
        .xm   (w_xm),
        .om   (w_om),
        .full (w_full)
    );

    assign w_is_line = (sel_q <= SEL_W'(LAST_LINE));
    assign w_is_full = (sel_q == SEL_W'(FULL_SEL));
    assign w_hit     = w_is_line & (w_xm | w_om);
    assign w_hit_who = w_xm ? WIN_X : WIN_O;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        winner_d     = winner_q;
        line_d       = line_q;
        bx_d         = bx_q;
        bo_d         = bo_q;
        found_d      = found_q;
        who_d        = who_q;
        idx_d        = idx_q;
        w_report     = 1'b0;
        w_rep_winner = WIN_NONE;
        w_rep_line   = NO_LINE;

        case (state_q)
            IDLE: begin
                // The done cycle still belongs to the finished scan, so start is not taken.
                if (start && !done_q) begin
                    bx_d    = board_x;
                    bo_d    = board_o;
                    sel_d   = '0;
                    busy_d  = 1'b1;
                    found_d = 1'b0;
                    who_d   = WIN_NONE;
                    idx_d   = NO_LINE;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (w_hit && !found_q) begin
                    found_d = 1'b1;
                    who_d   = w_hit_who;
                    idx_d   = 4'(sel_q);
                end
`ifdef TTT_WIN_SCAN_EARLY_EXIT_EN
                if (w_hit) begin
                    w_report     = 1'b1;
                    w_rep_winner = w_hit_who;
                    w_rep_line   = 4'(sel_q);
                end else
`endif
                if (w_is_full) begin
                    w_report = 1'b1;
                    if (found_q) begin
                        w_rep_winner = who_q;
                        w_rep_line   = idx_q;
                    end else if (w_full) begin
                        w_rep_winner = WIN_DRAW;
                    end
                end

                if (w_report) begin
                    done_d   = 1'b1;
                    winner_d = w_rep_winner;
                    line_d   = w_rep_line;
                    busy_d   = 1'b0;
                    sel_d    = '0;
                    state_d  = IDLE;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            winner_q <= WIN_NONE;
            line_q   <= NO_LINE;
            bx_q     <= '0;
            bo_q     <= '0;
            found_q  <= 1'b0;
            who_q    <= WIN_NONE;
            idx_q    <= NO_LINE;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            winner_q <= winner_d;
            line_q   <= line_d;
            bx_q     <= bx_d;
            bo_q     <= bo_d;
            found_q  <= found_d;
            who_q    <= who_d;
            idx_q    <= idx_d;
        end
    end

    assign mux.mux_sel = sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign winner      = winner_q;
    assign win_line    = line_q;

endmodule

`default_nettype wire

// File: tb/tb_ttt_win_scan.sv
// ============================================================================
//  Module   : tb_ttt_win_scan
//  Purpose  : Self-checking bench for ttt_win_scan against a cell-level game
//             model, with the canonical pattern mux wired to the interface.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ttt_win_scan;
    import ttt_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] board_x = 9'h000;
    logic [8:0] board_o = 9'h000;
    logic       busy, done;
    logic [1:0] winner;
    logic [3:0] win_line;

    int checks   = 0;
    int failures = 0;

    // Win lines as cell-index triples, in mux select order.
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                         '{0,3,6}, '{1,4,7}, '{2,5,8},
                         '{0,4,8}, '{2,4,6}};

    ttt_win_scan_if #(.SEL_W(4), .CELLS(9)) bus ();
    assign bus.mux_out = canon_mask(bus.mux_sel);

    ttt_win_scan #(.CELLS(9), .SEL_W(4), .LAST_LINE(7), .FULL_SEL(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .board_x  (board_x),
        .board_o  (board_o),
        .mux      (bus),
        .busy     (busy),
        .done     (done),
        .winner   (winner),
        .win_line (win_line)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [8:0] bx, input logic [8:0] bo,
                             output logic [1:0] w, output logic [3:0] l, output int lat);
        w   = 2'b00;
        l   = 4'hF;
        lat = 9;
        for (int i = 0; i < 8; i++) begin
            if (w == 2'b00) begin
                if (bx[lines[i][0]] && bx[lines[i][1]] && bx[lines[i][2]])      w = 2'b01;
                else if (bo[lines[i][0]] && bo[lines[i][1]] && bo[lines[i][2]]) w = 2'b10;
                if (w != 2'b00) begin
                    l = 4'(i);
`ifdef TTT_WIN_SCAN_EARLY_EXIT_EN
                    lat = i + 1;
`endif
                end
            end
        end
        if (w == 2'b00 && (bx | bo) == 9'h1FF) w = 2'b11;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"},    32'(bus.mux_sel), 32'd0);
        check({tag, "_busy"},   32'(busy),        32'd0);
        check({tag, "_done"},   32'(done),        32'd0);
        check({tag, "_winner"}, 32'(winner),      32'd0);
        check({tag, "_line"},   32'(win_line),    32'hF);
    endtask

    // Start a scan, scramble the inputs afterwards, and check result and latency.
    task automatic run_scan(input string tag, input logic [8:0] bx, input logic [8:0] bo);
        logic [1:0] ew;
        logic [3:0] el;
        int         elat;
        int         n;
        int         max_sel;
        ref_model(bx, bo, ew, el, elat);
        @(negedge clk);
        board_x = bx;
        board_o = bo;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        board_x = 9'($urandom);
        board_o = 9'($urandom);
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        n       = 0;
        max_sel = int'(bus.mux_sel);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (int'(bus.mux_sel) > max_sel) max_sel = int'(bus.mux_sel);
        end
        check({tag, "_done_seen"}, 32'(done),     32'd1);
        check({tag, "_latency"},   32'(n),        32'(elat));
        check({tag, "_winner"},    32'(winner),   32'(ew));
        check({tag, "_line"},      32'(win_line), 32'(el));
        check({tag, "_busy_end"},  32'(busy),     32'd0);
        check({tag, "_sel_max"},   32'(max_sel <= 8), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int         dones;
        int         first_n;
        logic [1:0] first_w;
        logic [8:0] rx, ro;

        // Reset held, then released.
        repeat (2) @(negedge clk);
        check_reset_vals("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_rel");

        // Directed scenarios.
        run_scan("x_top_row",  9'h007, 9'h018);
        run_scan("o_anti_diag", 9'h103, 9'h054);
        run_scan("draw",       9'h18D, 9'h072);
        run_scan("empty",      9'h000, 9'h000);
        run_scan("both_line0", 9'h007, 9'h007);

        // Start and new boards mid-scan (start sampled at E3) are ignored.
        @(negedge clk);
        board_x = 9'h18D;
        board_o = 9'h072;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        board_x = 9'h1FF;
        board_o = 9'h000;
        dones   = 0;
        first_n = 0;
        first_w = 2'b00;
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) start = 1'b1;
            @(negedge clk);
            if (c == 3) start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_n = c;
                    first_w = winner;
                    start   = 1'b1; // arrives in the done cycle, must be ignored
                end
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("midscan_done_count", 32'(dones),   32'd1);
        check("midscan_latency",    32'(first_n), 32'd9);
        check("midscan_winner",     32'(first_w), 32'(2'b11));
        check("done_cycle_start_busy", 32'(busy), 32'd0);

        // Asynchronous reset at E4 aborts the scan.
        @(negedge clk);
        board_x = 9'h000;
        board_o = 9'h000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        run_scan("after_rst", 9'h111, 9'h006);

        // Randomized boards against the model.
        for (int i = 0; i < 24; i++) begin
            rx = 9'($urandom);
            ro = 9'($urandom);
            if (i % 4 != 3) ro = ro & ~rx;
            run_scan("rand", rx, ro);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
